// File: rtl/myo_spi_pkg.sv
// Shared types and helpers for the myo SPI responder.
// Frame layout, FSM state encoding, status snapshot payload and the
// tx word / checksum builders used by myo_spi_slave.
// Build option: MYO_SPI_CHECKSUM_EN adds a trailing XOR checksum word.
package myo_spi_pkg;

  localparam int unsigned FRAME_WORDS_BASE = 7;
`ifdef MYO_SPI_CHECKSUM_EN
  localparam int unsigned FRAME_WORDS = FRAME_WORDS_BASE + 1;
`else
  localparam int unsigned FRAME_WORDS = FRAME_WORDS_BASE;
`endif

  // Word index counter width; must hold FRAME_WORDS+1 (saturation value).
  localparam int unsigned IDX_W = 4;

  // Tx word indices within a frame.
  localparam int unsigned TX_STATUS   = 0;
  localparam int unsigned TX_POS_HI   = 1;
  localparam int unsigned TX_POS_LO   = 2;
  localparam int unsigned TX_VEL_HI   = 3;
  localparam int unsigned TX_VEL_LO   = 4;
  localparam int unsigned TX_DISP_HI  = 5;
  localparam int unsigned TX_DISP_LO  = 6;
  localparam int unsigned TX_CHECKSUM = 7;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    END    = 2'd3
  } state_e;

  // Status values frozen at frame start.
  typedef struct packed {
    logic [31:0] position;
    logic [31:0] velocity;
    logic [31:0] displacement;
  } status_t;

  // XOR of the seven data words of a frame.
  function automatic logic [15:0] frame_xor(input logic [FRAME_WORDS_BASE-1:0][15:0] w);
    frame_xor = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5] ^ w[6];
  endfunction

  // Tx word for a given index; indices past the frame return zero.
  function automatic logic [15:0] tx_word(input logic [IDX_W-1:0] idx,
                                          input logic [7:0]       id,
                                          input logic [7:0]       cnt,
                                          input status_t          s);
    logic [FRAME_WORDS_BASE-1:0][15:0] w;
    w[0] = {id, cnt};
    w[1] = s.position[31:16];
    w[2] = s.position[15:0];
    w[3] = s.velocity[31:16];
    w[4] = s.velocity[15:0];
    w[5] = s.displacement[31:16];
    w[6] = s.displacement[15:0];
    tx_word = 16'h0000;
    case (idx)
      IDX_W'(TX_STATUS):   tx_word = w[0];
      IDX_W'(TX_POS_HI):   tx_word = w[1];
      IDX_W'(TX_POS_LO):   tx_word = w[2];
      IDX_W'(TX_VEL_HI):   tx_word = w[3];
      IDX_W'(TX_VEL_LO):   tx_word = w[4];
      IDX_W'(TX_DISP_HI):  tx_word = w[5];
      IDX_W'(TX_DISP_LO):  tx_word = w[6];
`ifdef MYO_SPI_CHECKSUM_EN
      IDX_W'(TX_CHECKSUM): tx_word = frame_xor(w);
`endif
      default:             tx_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/myo_spi_if.sv
// SPI link wires between the FPGA master and the motor-board responder.
//   spi_sck   master clock (CPOL=0/CPHA=1)
//   spi_ss_n  active-low slave select
//   spi_mosi  master-out data
//   spi_miso  slave-out data
interface myo_spi_if;
  logic spi_sck;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sck, output spi_ss_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sck, input spi_ss_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/myo_spi_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin with edge strobes.
//   clock, reset_n  system clock / async active-low reset
//   din             raw pin
//   level           synchronized level (registered)
//   rise_c, fall_c  1-cycle strobes on synchronized transitions
module myo_spi_sync #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchronizer chain plus one extra flop for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level  = chain[STAGES-1];
  assign rise_c = chain[STAGES-1] & ~prev;
  assign fall_c = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/myo_spi_slave.sv
// myo SPI responder (motor-board end), CPOL=0/CPHA=1, MSB-first words,
// one frame per ss_n low window; all logic oversampled on clock.
//   clock, reset_n     system clock / async active-low reset
//   spi                SPI pins (slave modport); miso is 0 when not selected
//   position/velocity/displacement  status inputs, snapshotted at frame start
//   pwm_ref, pwm_ref_valid          accepted PWM reference and update pulse
//   frame_done, frame_error         end-of-frame result pulses
//   busy               high while a frame is being shifted
// Build option: MYO_SPI_CHECKSUM_EN (8-word frame with XOR checksum,
// pwm_ref committed only at the end of a good frame).
module myo_spi_slave
  import myo_spi_pkg::*;
#(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STATUS_ID   = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  myo_spi_if.slave          spi,
  input  logic [31:0]       position,
  input  logic [31:0]       velocity,
  input  logic [31:0]       displacement,
  output logic [WORD_W-1:0] pwm_ref,
  output logic              pwm_ref_valid,
  output logic              frame_done,
  output logic              frame_error,
  output logic              busy
);

  localparam int unsigned CNT_W      = $clog2(WORD_W);
  localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_MAX + 1);

  localparam logic [IDX_W-1:0] IDX_SAT   = IDX_W'(FRAME_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_FRAME = IDX_W'(FRAME_WORDS);

  // Synchronized pins and strobes
  logic sck_rise, sck_fall, sck_level_unused;
  logic ss_n_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  myo_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .din(spi.spi_sck),
    .level(sck_level_unused), .rise_c(sck_rise), .fall_c(sck_fall)
  );

  myo_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset_n(reset_n), .din(spi.spi_ss_n),
    .level(ss_n_s), .rise_c(ss_rise), .fall_c(ss_fall)
  );

  myo_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .din(spi.spi_mosi),
    .level(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  // State and datapath registers
  state_e              state_q,       state_d;
  logic [SETTLE_W-1:0] settle_q,      settle_d;
  logic [IDX_W-1:0]    word_idx_q,    word_idx_d;
  logic [CNT_W-1:0]    bit_cnt_q,     bit_cnt_d;
  logic [WORD_W-1:0]   tx_shift_q,    tx_shift_d;
  logic [WORD_W-1:0]   rx_shift_q,    rx_shift_d;
  status_t             snap_q,        snap_d;
  logic [7:0]          frame_cnt_q,   frame_cnt_d;
  logic [WORD_W-1:0]   pwm_ref_q,     pwm_ref_d;
  logic                pwm_valid_q,   pwm_valid_d;
  logic                done_q,        done_d;
  logic                error_q,       error_d;
  logic                busy_q,        busy_d;
  logic                miso_q,        miso_d;
`ifdef MYO_SPI_CHECKSUM_EN
  logic [WORD_W-1:0]   rx_xor_q,      rx_xor_d;
  logic                chk_ok_q,      chk_ok_d;
  logic [WORD_W-1:0]   pwm_hold_q,    pwm_hold_d;
`endif

  logic [WORD_W-1:0]   rx_word_c;
  logic [IDX_W-1:0]    next_idx_c;
  logic                word_done_c;
  logic                frame_ok_c;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    word_idx_d  = word_idx_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    pwm_ref_d   = pwm_ref_q;
    pwm_valid_d = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    miso_d      = miso_q;
`ifdef MYO_SPI_CHECKSUM_EN
    rx_xor_d    = rx_xor_q;
    chk_ok_d    = chk_ok_q;
    pwm_hold_d  = pwm_hold_q;
`endif

    rx_word_c   = {rx_shift_q[WORD_W-2:0], mosi_s};
    next_idx_c  = (word_idx_q == IDX_SAT) ? IDX_SAT : word_idx_q + IDX_W'(1);
    word_done_c = sck_fall && (bit_cnt_q == CNT_W'(WORD_W - 1));
`ifdef MYO_SPI_CHECKSUM_EN
    frame_ok_c  = (word_idx_q == IDX_FRAME) && (bit_cnt_q == '0) && chk_ok_q;
`else
    frame_ok_c  = (word_idx_q == IDX_FRAME) && (bit_cnt_q == '0);
`endif

    unique case (state_q)
      // Wait for the synchronizers to settle after reset, then for ss_n
      // high, so a frame already in progress at reset release is skipped.
      RESYNC: begin
        if (settle_q != SETTLE_W'(SETTLE_MAX)) begin
          settle_d = settle_q + SETTLE_W'(1);
        end else if (ss_n_s) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          snap_d     = status_t'({position, velocity, displacement});
          word_idx_d = '0;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = WORD_W'(tx_word(IDX_W'(TX_STATUS), STATUS_ID, frame_cnt_q,
                                       status_t'({position, velocity, displacement})));
`ifdef MYO_SPI_CHECKSUM_EN
          rx_xor_d   = '0;
          chk_ok_d   = 1'b0;
`endif
        end
      end

      // ss_rise wins over any sck edge seen in the same cycle.
      ACTIVE: begin
        if (ss_rise) begin
          state_d = END;
        end else begin
          if (sck_rise) begin
            miso_d     = tx_shift_q[WORD_W-1];
            tx_shift_d = tx_shift_q << 1;
          end
          if (sck_fall) begin
            rx_shift_d = rx_word_c;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
          if (word_done_c) begin
            bit_cnt_d  = '0;
            word_idx_d = next_idx_c;
            tx_shift_d = WORD_W'(tx_word(next_idx_c, STATUS_ID, frame_cnt_q, snap_q));
`ifdef MYO_SPI_CHECKSUM_EN
            if (word_idx_q < IDX_W'(FRAME_WORDS - 1)) rx_xor_d = rx_xor_q ^ rx_word_c;
            if (word_idx_q == IDX_W'(FRAME_WORDS - 1)) chk_ok_d = (rx_word_c == rx_xor_q);
            if (word_idx_q == '0) pwm_hold_d = rx_word_c;
`else
            if (word_idx_q == '0) begin
              pwm_ref_d   = rx_word_c;
              pwm_valid_d = 1'b1;
            end
`endif
          end
        end
      end

      END: begin
        state_d = IDLE;
        if (frame_ok_c) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
`ifdef MYO_SPI_CHECKSUM_EN
          pwm_ref_d   = pwm_hold_q;
          pwm_valid_d = 1'b1;
`endif
        end else begin
          error_d = 1'b1;
        end
      end

      default: state_d = RESYNC;
    endcase

    if (state_d != ACTIVE) miso_d = 1'b0;
    busy_d = (state_d == ACTIVE);
  end

  // Register bank
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESYNC;
      settle_q    <= '0;
      word_idx_q  <= '0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      snap_q      <= '0;
      frame_cnt_q <= '0;
      pwm_ref_q   <= '0;
      pwm_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
`ifdef MYO_SPI_CHECKSUM_EN
      rx_xor_q    <= '0;
      chk_ok_q    <= 1'b0;
      pwm_hold_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      word_idx_q  <= word_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      snap_q      <= snap_d;
      frame_cnt_q <= frame_cnt_d;
      pwm_ref_q   <= pwm_ref_d;
      pwm_valid_q <= pwm_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
`ifdef MYO_SPI_CHECKSUM_EN
      rx_xor_q    <= rx_xor_d;
      chk_ok_q    <= chk_ok_d;
      pwm_hold_q  <= pwm_hold_d;
`endif
    end
  end

  assign spi.spi_miso  = miso_q;
  assign pwm_ref       = pwm_ref_q;
  assign pwm_ref_valid = pwm_valid_q;
  assign frame_done    = done_q;
  assign frame_error   = error_q;
  assign busy          = busy_q;

endmodule
